// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: arbitrates a fetch port and a data port onto one
// RAM handshake (MOV/MOC/MOCoff), one access at a time.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   f_req, f_addr     fetch request (word read) and address
//   f_ack             one-cycle fetch completion pulse
//   d_req, d_rw       data request, direction (1 = read, 0 = write)
//   d_ms              data size/sign code, forwarded to MS_2_0
//   d_addr, d_wdata   data address and write value
//   d_ack             one-cycle data completion pulse
//   rdata, err        read result and timeout flag, valid with an ack
//   MOV, ReadWrite    RAM operation strobe and direction
//   MS_2_0            RAM size code
//   Address, DataIn   RAM address and write data
//   MOCoff            RAM completion-clear strobe
//   MOC, DataOut      RAM completion flag and read data
//
// Optional feature: define MEM_TIMEOUT_EN to enable an ACCESS watchdog
// that completes a stalled access with err=1 after TIMEOUT_CYCLES.

module mem_arbiter_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_BURST_MAX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ack,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [2:0]  d_ms,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        MOV,
    output logic        ReadWrite,
    output logic [2:0]  MS_2_0,
    output logic [31:0] Address,
    output logic [31:0] DataIn,
    output logic        MOCoff,
    input  logic        MOC,
    input  logic [31:0] DataOut
);

    localparam int BW = (DATA_BURST_MAX > 0) ?
                        $clog2(DATA_BURST_MAX + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RELEASE
    } state_e;

    state_e      state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic        gnt_f_q, gnt_f_d;
    logic        mov_q, mov_d;
    logic        mocoff_q, mocoff_d;
    logic        f_ack_q, f_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        rw_q, rw_d;
    logic [2:0]  ms_q, ms_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pick_f;
    logic        burst_full;
    logic        done;

`ifdef MEM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`endif

    assign burst_full = (burst_q == BW'(DATA_BURST_MAX));
    // Data normally wins; a saturated burst counter lets fetch through.
    assign pick_f = f_req & (~d_req | burst_full);

    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        gnt_f_d  = gnt_f_q;
        mov_d    = mov_q;
        mocoff_d = mocoff_q;
        f_ack_d  = 1'b0;
        d_ack_d  = 1'b0;
        rw_d     = rw_q;
        ms_d     = ms_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        done     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif

        // No fetch waiting means no starvation to track.
        if (!f_req) begin
            burst_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (f_req || d_req) begin
                    mov_d   = 1'b1;
                    state_d = ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (pick_f) begin
                        gnt_f_d = 1'b1;
                        rw_d    = 1'b1;
                        ms_d    = 3'b010;
                        addr_d  = f_addr;
                        wdata_d = '0;
                        burst_d = '0;
                    end else begin
                        gnt_f_d = 1'b0;
                        rw_d    = d_rw;
                        ms_d    = d_ms;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        if (f_req && !burst_full) begin
                            burst_d = burst_q + BW'(1);
                        end
                    end
                end
            end

            ACCESS: begin
                if (MOC) begin
                    done    = 1'b1;
                    rdata_d = rw_q ? DataOut : '0;
`ifdef MEM_TIMEOUT_EN
                end else if (cnt_q == TLAST) begin
                    done    = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d   = cnt_q + TW'(1);
`endif
                end

                if (done) begin
                    f_ack_d  = gnt_f_q;
                    d_ack_d  = ~gnt_f_q;
                    mov_d    = 1'b0;
                    mocoff_d = 1'b1;
                    state_d  = RELEASE;
                end
            end

            RELEASE: begin
                if (!MOC) begin
                    mocoff_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            burst_q  <= '0;
            gnt_f_q  <= 1'b0;
            mov_q    <= 1'b0;
            mocoff_q <= 1'b0;
            f_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            rw_q     <= 1'b0;
            ms_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            gnt_f_q  <= gnt_f_d;
            mov_q    <= mov_d;
            mocoff_q <= mocoff_d;
            f_ack_q  <= f_ack_d;
            d_ack_q  <= d_ack_d;
            rw_q     <= rw_d;
            ms_q     <= ms_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign f_ack     = f_ack_q;
    assign d_ack     = d_ack_q;
    assign rdata     = rdata_q;
    assign MOV       = mov_q;
    assign MOCoff    = mocoff_q;
    assign ReadWrite = rw_q;
    assign MS_2_0    = ms_q;
    assign Address   = addr_q;
    assign DataIn    = wdata_q;

`ifdef MEM_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter_ctrl.md
MEM_ARBITER_CTRL -- requirements
Module: mem_arbiter_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, number of ACCESS cycles allowed without MOC (used only with MEM_TIMEOUT_EN).
REQ-002 Parameter: DATA_BURST_MAX, default 2, maximum consecutive data grants while a fetch is pending.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: f_req  in  1  fetch request; always a word read.
REQ-006 Port: f_addr  in  32  fetch address.
REQ-007 Port: f_ack  out  1  one-cycle pulse; fetch access complete.
REQ-008 Port: d_req  in  1  data request.
REQ-009 Port: d_rw  in  1  data direction; 1 = read, 0 = write.
REQ-010 Port: d_ms  in  3  data size/sign code, passed to MS_2_0 unchanged.
REQ-011 Port: d_addr  in  32  data address.
REQ-012 Port: d_wdata  in  32  data write value.
REQ-013 Port: d_ack  out  1  one-cycle pulse; data access complete.
REQ-014 Port: rdata  out  32  read result, valid in the f_ack/d_ack cycle.
REQ-015 Port: err  out  1  timeout flag, valid in the ack cycle.
REQ-016 Port: MOV, ReadWrite  out  1 each  RAM operation strobe and direction.
REQ-017 Port: MS_2_0  out  3; Address, DataIn  out  32 each  RAM size code, address and write data.
REQ-018 Port: MOCoff  out  1  RAM completion-clear strobe.
REQ-019 Port: MOC  in  1; DataOut  in  32  RAM completion flag and read data.

Function
REQ-020 The FSM SHALL have three states: IDLE, ACCESS and RELEASE.
REQ-021 IDLE: on an edge with any request pending, latch the winner's address, rw, ms and wdata into the RAM outputs, set MOV=1 and go to ACCESS.
REQ-022 A fetch grant SHALL drive ReadWrite=1 and MS_2_0=3'b010.
REQ-023 Arbitration: d_req wins over f_req, except that f_req wins when the data-burst counter equals DATA_BURST_MAX.
REQ-024 Burst counter: increments on a data grant while f_req=1; clears on any fetch grant or when f_req=0; saturates at DATA_BURST_MAX.
REQ-025 ACCESS: MOV and the latched RAM outputs are held stable until MOC is sampled 1.
REQ-026 On the edge where MOC=1 in ACCESS: capture DataOut into rdata (write access: rdata=0), pulse the granted port's ack for exactly one cycle, set MOV=0 and MOCoff=1, and go to RELEASE.
REQ-027 RELEASE: hold MOCoff=1 until MOC is sampled 0, then set MOCoff=0 and go to IDLE; no new grant is issued from RELEASE.
REQ-028 Minimum access: 3 cycles from the grant edge to the next possible grant edge.
REQ-029 Requesters hold req and operands until their ack; req deasserted during ACCESS SHALL NOT abort the access.
REQ-030 Only one ack SHALL be high in any cycle; err=0 except as stated in REQ-036.

Reset
REQ-031 Reset SHALL force state IDLE, burst counter 0, and all outputs to 0 (MOV, MOCoff, f_ack, d_ack, err, ReadWrite, MS_2_0, Address, DataIn, rdata).
REQ-032 Reset asserted during ACCESS or RELEASE abandons the access with no ack; the first grant is possible on the first edge after reset deasserts.

Configuration
REQ-033 Macro MEM_TIMEOUT_EN enables the ACCESS watchdog.
REQ-034 With the macro defined, a cycle counter clears on entry to ACCESS and counts each ACCESS cycle.
REQ-035 Without the macro, ACCESS waits indefinitely for MOC and err is tied to 0.
REQ-036 When the counter reaches TIMEOUT_CYCLES with MOC=0: pulse ack with err=1 and rdata=0, then proceed as in REQ-026.

Verification
REQ-037 Fetch only: f_req=1, f_addr=0x10, RAM returns MOC after 2 cycles with DataOut=0xDEADBEEF -> MOV=1, ReadWrite=1, MS_2_0=010, Address=0x10; one f_ack with rdata=0xDEADBEEF; MOCoff pulses until MOC drops.
REQ-038 Data write byte: d_rw=0, d_ms=000, d_addr=0x05, d_wdata=0xAB -> ReadWrite=0, MS_2_0=000, DataIn=0xAB; one d_ack; rdata=0.
REQ-039 Contention: f_req and d_req held continuously -> grant order D, D, F, D, D, F; no cycle has both acks high.
REQ-040 Reset mid-ACCESS: reset during MOV=1 -> next cycle MOV=0, no ack; a new request is granted on the first edge after reset deasserts.
REQ-041 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, MOC never asserted -> ack with err=1 and rdata=0 after 4 ACCESS cycles, then return to IDLE; without the macro, MOV stays 1 indefinitely.
